// File: rtl/win_scan_fsm_pkg.sv
// Shared board definitions for the connect-N game core.
// Holds the default board geometry, the scan direction and FSM state
// encodings, and the per-direction step table used by the win scanner.
// The drop/column-height logic uses the same geometry defaults.
package win_scan_fsm_pkg;

  localparam int COLS_DEF    = 7;
  localparam int ROWS_DEF    = 6;
  localparam int WIN_LEN_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_VERT    = 2'd0,
    DIR_HORIZ   = 2'd1,
    DIR_DIAG_UR = 2'd2,
    DIR_DIAG_DR = 2'd3
  } dir_e;

  // One cell step along a direction, as signed column/row deltas.
  typedef struct packed {
    logic signed [1:0] dc;
    logic signed [1:0] dr;
  } step_t;

  // Positive-side steps; the negative side is the same vector negated.
  localparam step_t STEP_POS [4] = '{
    '{dc: 2'sb00, dr: 2'sb01},   // vertical: up
    '{dc: 2'sb01, dr: 2'sb00},   // horizontal: right
    '{dc: 2'sb01, dr: 2'sb01},   // diagonal up-right
    '{dc: 2'sb01, dr: 2'sb11}    // diagonal down-right
  };

  function automatic step_t step_of(input dir_e d, input logic neg);
    step_t s;
    s = STEP_POS[d];
    if (neg) begin
      s.dc = -s.dc;
      s.dr = -s.dr;
    end
    return s;
  endfunction

endpackage

// File: rtl/win_scan_fsm_board_cell_lookup.sv
// board_cell_lookup: combinational probe of one board cell.
// Ports:
//   probe_col, probe_row  signed, width-extended coordinates (may be off-board)
//   player_board          per-cell owner bit, index = ROWS*col + row
//   onoff_board           per-cell occupied bit
//   in_bounds             coordinate lies on the board
//   occupied, owner       cell bits, forced to 0 when off-board
module board_cell_lookup
  import win_scan_fsm_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int CW   = $clog2(COLS_DEF) + 2,
  parameter int RW   = $clog2(ROWS_DEF) + 2
) (
  input  logic signed [CW-1:0]        probe_col,
  input  logic signed [RW-1:0]        probe_row,
  input  logic        [COLS*ROWS-1:0] player_board,
  input  logic        [COLS*ROWS-1:0] onoff_board,
  output logic                        in_bounds,
  output logic                        occupied,
  output logic                        owner
);

  localparam int IDX_W = $clog2(COLS * ROWS);
  localparam logic signed [CW-1:0] COL_LIM = CW'(COLS);
  localparam logic signed [RW-1:0] ROW_LIM = RW'(ROWS);

  logic [IDX_W-1:0] idx;

  always_comb begin
    // Sign bit test catches -1 before it could alias onto a far-side cell.
    in_bounds = !probe_col[CW-1] && (probe_col < COL_LIM) &&
                !probe_row[RW-1] && (probe_row < ROW_LIM);
    idx = '0;
    if (in_bounds) begin
      idx = IDX_W'(ROWS * int'(probe_col) + int'(probe_row));
    end
    occupied = in_bounds && onoff_board[idx];
    owner    = in_bounds && player_board[idx];
  end

endmodule

// File: rtl/win_scan_fsm.sv
// win_scan_fsm: sequential connect-N win checker.
// On start it snapshots both boards and the last move, validates the origin,
// then walks one cell per clock along vertical, horizontal and both diagonals
// (positive side first, then negative side) counting same-player discs.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 scan request, accepted only when idle
//   player, col, row      last move
//   player_board          per-cell owner bit
//   onoff_board           per-cell occupied bit
//   busy                  accepted start until done
//   done                  one-cycle completion pulse
//   win, win_dir, run_len results, held until the next accepted start
//   bad_move              origin off-board, empty, or owned by the other player
module win_scan_fsm
  import win_scan_fsm_pkg::*;
#(
  parameter  int COLS    = COLS_DEF,
  parameter  int ROWS    = ROWS_DEF,
  parameter  int WIN_LEN = WIN_LEN_DEF,
  localparam int COL_W   = $clog2(COLS),
  localparam int ROW_W   = $clog2(ROWS),
  localparam int CNT_W   = $clog2(WIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 player,
  input  logic [COL_W-1:0]     col,
  input  logic [ROW_W-1:0]     row,
  input  logic [COLS*ROWS-1:0] player_board,
  input  logic [COLS*ROWS-1:0] onoff_board,
  output logic                 busy,
  output logic                 done,
  output logic                 win,
  output logic [1:0]           win_dir,
  output logic [CNT_W-1:0]     run_len,
  output logic                 bad_move
);

  // Two guard bits: one for the +1 step past the last cell, one for sign.
  localparam int CW = COL_W + 2;
  localparam int RW = ROW_W + 2;

  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d;
  logic                  neg_q, neg_d;
  logic signed [CW-1:0]  cur_c_q, cur_c_d;
  logic signed [RW-1:0]  cur_r_q, cur_r_d;
  logic [CNT_W-1:0]      run_q, run_d;
  logic                  win_q, win_d;
  logic [1:0]            win_dir_q, win_dir_d;
  logic                  bad_q, bad_d;
  logic                  done_q;

  logic                  player_q;
  logic signed [CW-1:0]  org_c_q;
  logic signed [RW-1:0]  org_r_q;
  logic [COLS*ROWS-1:0]  pb_q, oo_q;

  step_t                 st;
  logic signed [CW-1:0]  probe_c;
  logic signed [RW-1:0]  probe_r;
  logic                  in_bounds, occupied, owner, match;

  // LOAD probes the origin itself; SCAN probes one step beyond the cursor.
  always_comb begin
    st = step_of(dir_q, neg_q);
    if (state_q == S_LOAD) begin
      probe_c = org_c_q;
      probe_r = org_r_q;
    end else begin
      probe_c = cur_c_q + CW'(st.dc);
      probe_r = cur_r_q + RW'(st.dr);
    end
  end

  board_cell_lookup #(
    .COLS(COLS),
    .ROWS(ROWS),
    .CW  (CW),
    .RW  (RW)
  ) u_lookup (
    .probe_col   (probe_c),
    .probe_row   (probe_r),
    .player_board(pb_q),
    .onoff_board (oo_q),
    .in_bounds   (in_bounds),
    .occupied    (occupied),
    .owner       (owner)
  );

  assign match = in_bounds && occupied && (owner == player_q);

  always_comb begin
    // NOTE: every target takes its held value first, so no path infers a latch.
    state_d   = state_q;
    dir_d     = dir_q;
    neg_d     = neg_q;
    cur_c_d   = cur_c_q;
    cur_r_d   = cur_r_q;
    run_d     = run_q;
    win_d     = win_q;
    win_dir_d = win_dir_q;
    bad_d     = bad_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          win_d     = 1'b0;
          win_dir_d = DIR_VERT;
          run_d     = '0;
          bad_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (!match) begin
          bad_d   = 1'b1;
          run_d   = '0;
          state_d = S_DONE;
        end else begin
          run_d   = CNT_W'(1);
          dir_d   = DIR_VERT;
          neg_d   = 1'b0;
          cur_c_d = org_c_q;
          cur_r_d = org_r_q;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (match) begin
          run_d   = run_q + CNT_W'(1);
          cur_c_d = probe_c;
          cur_r_d = probe_r;
          // Stopping at WIN_LEN is what saturates the reported run length.
          if (run_d == CNT_W'(WIN_LEN)) begin
            win_d     = 1'b1;
            win_dir_d = dir_q;
            state_d   = S_DONE;
          end
        end else if (!neg_q) begin
          neg_d   = 1'b1;
          cur_c_d = org_c_q;
          cur_r_d = org_r_q;
        end else if (dir_q == DIR_DIAG_DR) begin
          state_d = S_DONE;
        end else begin
          dir_d   = dir_e'(dir_q + 2'd1);
          neg_d   = 1'b0;
          run_d   = CNT_W'(1);
          cur_c_d = org_c_q;
          cur_r_d = org_r_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_VERT;
      neg_q     <= 1'b0;
      cur_c_q   <= '0;
      cur_r_q   <= '0;
      run_q     <= '0;
      win_q     <= 1'b0;
      win_dir_q <= 2'd0;
      bad_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      neg_q     <= neg_d;
      cur_c_q   <= cur_c_d;
      cur_r_q   <= cur_r_d;
      run_q     <= run_d;
      win_q     <= win_d;
      win_dir_q <= win_dir_d;
      bad_q     <= bad_d;
      // The pulse lands on the edge that leaves DONE, together with busy falling.
      done_q    <= (state_q == S_DONE);
    end
  end

  // NOTE: the board snapshot and move latch carry no reset; they are only
  // read after being loaded by an accepted start.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      player_q <= player;
      org_c_q  <= $signed(CW'(col));
      org_r_q  <= $signed(RW'(row));
      pb_q     <= player_board;
      oo_q     <= onoff_board;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign win      = win_q;
  assign win_dir  = win_dir_q;
  assign run_len  = run_q;
  assign bad_move = bad_q;

endmodule

// File: tb/tb_win_scan_fsm.sv
// Scoreboard bench for win_scan_fsm: a default 7x6/4 instance and a 9x8/5
// instance. Stimulus pushes expected results (with done cycle) into a queue
// per instance; a monitor per instance pops and compares on each done pulse.
module tb_win_scan_fsm;

  typedef struct {
    logic       win;
    logic [1:0] dir;
    int         run;
    logic       bad;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance (7x6, WIN_LEN 4)
  logic        s_start, s_player, s_busy, s_done, s_win, s_bad;
  logic [2:0]  s_col, s_row, s_run;
  logic [1:0]  s_dir;
  logic [41:0] s_pb, s_oo;
  exp_t        s_q[$];
  int          s_done_cnt = 0;

  win_scan_fsm u_small (
    .clk(clk), .reset(reset), .start(s_start), .player(s_player),
    .col(s_col), .row(s_row), .player_board(s_pb), .onoff_board(s_oo),
    .busy(s_busy), .done(s_done), .win(s_win), .win_dir(s_dir),
    .run_len(s_run), .bad_move(s_bad)
  );

  // Large instance (9x8, WIN_LEN 5)
  logic        b_start, b_player, b_busy, b_done, b_win, b_bad;
  logic [3:0]  b_col;
  logic [2:0]  b_row, b_run;
  logic [1:0]  b_dir;
  logic [71:0] b_pb, b_oo;
  exp_t        b_q[$];
  int          b_done_cnt = 0;

  win_scan_fsm #(.COLS(9), .ROWS(8), .WIN_LEN(5)) u_big (
    .clk(clk), .reset(reset), .start(b_start), .player(b_player),
    .col(b_col), .row(b_row), .player_board(b_pb), .onoff_board(b_oo),
    .busy(b_busy), .done(b_done), .win(b_win), .win_dir(b_dir),
    .run_len(b_run), .bad_move(b_bad)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic w, input logic [1:0] d, input int r,
                              input logic bad, input int lat);
    exp_t e;
    e.win = w; e.dir = d; e.run = r; e.bad = bad; e.cyc = lat;
    return e;
  endfunction

  always @(negedge clk) begin : mon_small
    exp_t e;
    if (s_done === 1'b1) begin
      if (s_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL s_unexpected_done: done seen with no scan pending (cycle %0d)", cyc);
      end else begin
        e = s_q.pop_front();
        check("s_win", s_win, e.win);
        check("s_win_dir", s_dir, e.dir);
        check("s_run_len", s_run, e.run);
        check("s_bad_move", s_bad, e.bad);
        check("s_done_cycle", cyc, e.cyc);
        check("s_busy_at_done", s_busy, 0);
      end
      s_done_cnt++;
    end
  end

  always @(negedge clk) begin : mon_big
    exp_t e;
    if (b_done === 1'b1) begin
      if (b_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL b_unexpected_done: done seen with no scan pending (cycle %0d)", cyc);
      end else begin
        e = b_q.pop_front();
        check("b_win", b_win, e.win);
        check("b_win_dir", b_dir, e.dir);
        check("b_run_len", b_run, e.run);
        check("b_bad_move", b_bad, e.bad);
        check("b_done_cycle", cyc, e.cyc);
        check("b_busy_at_done", b_busy, 0);
      end
      b_done_cnt++;
    end
  end

  task automatic put_s(input int c, input int r, input logic p);
    s_oo[6*c + r] = 1'b1;
    s_pb[6*c + r] = p;
  endtask

  task automatic put_b(input int c, input int r, input logic p);
    b_oo[8*c + r] = 1'b1;
    b_pb[8*c + r] = p;
  endtask

  // Issue one scan; e.cyc carries the expected latency in edges.
  task automatic scan_s(input logic p, input int c, input int r, input exp_t e);
    int cnt0;
    @(negedge clk);
    s_player = p; s_col = 3'(c); s_row = 3'(r); s_start = 1'b1;
    e.cyc = cyc + 1 + e.cyc;
    s_q.push_back(e);
    cnt0 = s_done_cnt;
    @(negedge clk);
    s_start = 1'b0;
    // Scramble the live boards; only the snapshot may be used.
    s_pb = '0; s_oo = '1;
    for (int i = 0; i < 60 && s_done_cnt == cnt0; i++) @(posedge clk);
    if (s_done_cnt == cnt0) begin
      n_vec++; n_bad++;
      $display("FAIL s_timeout: no done within 60 cycles (cycle %0d)", cyc);
    end
    repeat (2) @(negedge clk);
    check("s_win_hold", s_win, e.win);
    s_pb = '0; s_oo = '0;
  endtask

  task automatic scan_b(input logic p, input int c, input int r, input exp_t e);
    int cnt0;
    @(negedge clk);
    b_player = p; b_col = 4'(c); b_row = 3'(r); b_start = 1'b1;
    e.cyc = cyc + 1 + e.cyc;
    b_q.push_back(e);
    cnt0 = b_done_cnt;
    @(negedge clk);
    b_start = 1'b0;
    b_pb = '0; b_oo = '1;
    for (int i = 0; i < 60 && b_done_cnt == cnt0; i++) @(posedge clk);
    if (b_done_cnt == cnt0) begin
      n_vec++; n_bad++;
      $display("FAIL b_timeout: no done within 60 cycles (cycle %0d)", cyc);
    end
    repeat (2) @(negedge clk);
    check("b_win_hold", b_win, e.win);
    b_pb = '0; b_oo = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1;
    s_start = 1'b0; s_player = 1'b0; s_col = '0; s_row = '0; s_pb = '0; s_oo = '0;
    b_start = 1'b0; b_player = 1'b0; b_col = '0; b_row = '0; b_pb = '0; b_oo = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", s_busy, 0);
    check("reset_done", s_done, 0);
    check("reset_win", s_win, 0);
    check("reset_run_len", s_run, 0);
    check("reset_bad_move", s_bad, 0);
    check("reset_win_dir", s_dir, 0);
    reset = 1'b0;

    // 1: vertical, run from the top disc downward
    for (int r = 0; r < 4; r++) put_s(0, r, 1'b1);
    scan_s(1'b1, 0, 3, mk(1'b1, 2'd0, 4, 1'b0, 6));

    // 2: horizontal, both sides contribute
    for (int c = 1; c < 5; c++) put_s(c, 0, 1'b0);
    scan_s(1'b0, 2, 0, mk(1'b1, 2'd1, 4, 1'b0, 8));

    // 3: up-right diagonal ending on the right edge
    for (int k = 0; k < 4; k++) put_s(3 + k, k, 1'b1);
    scan_s(1'b1, 6, 3, mk(1'b1, 2'd2, 4, 1'b0, 10));

    // 4: lone disc in the corner, decoys where a wrapped index would land
    put_s(0, 0, 1'b1);
    put_s(6, 0, 1'b1); put_s(5, 5, 1'b1); put_s(6, 5, 1'b1); put_s(6, 1, 1'b1);
    scan_s(1'b1, 0, 0, mk(1'b0, 2'd0, 1, 1'b0, 10));

    // 5: invalid origins
    scan_s(1'b1, 3, 3, mk(1'b0, 2'd0, 0, 1'b1, 2));
    put_s(0, 0, 1'b1);
    scan_s(1'b1, 7, 0, mk(1'b0, 2'd0, 0, 1'b1, 2));
    put_s(0, 0, 1'b1);
    scan_s(1'b0, 0, 0, mk(1'b0, 2'd0, 0, 1'b1, 2));

    // 6a: reset in the middle of a scan aborts it without done
    for (int r = 0; r < 4; r++) put_s(0, r, 1'b1);
    @(negedge clk);
    s_player = 1'b1; s_col = 3'd0; s_row = 3'd3; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_scan_busy", s_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", s_busy, 0);
    check("abort_done", s_done, 0);
    check("abort_win", s_win, 0);
    check("abort_run_len", s_run, 0);
    check("abort_bad_move", s_bad, 0);
    check("abort_win_dir", s_dir, 0);
    repeat (15) @(negedge clk);

    // 6b: start held through busy produces exactly one scan
    @(negedge clk);
    s_player = 1'b1; s_col = 3'd0; s_row = 3'd3; s_start = 1'b1;
    s_q.push_back(mk(1'b1, 2'd0, 4, 1'b0, cyc + 1 + 6));
    for (int i = 0; i < 60 && s_done !== 1'b1; i++) @(negedge clk);
    s_start = 1'b0;
    repeat (15) @(negedge clk);
    check("held_start_scans", s_done_cnt, 8);
    s_pb = '0; s_oo = '0;

    // Large board: 1-3 with WIN_LEN 5
    for (int r = 0; r < 5; r++) put_b(0, r, 1'b1);
    scan_b(1'b1, 0, 4, mk(1'b1, 2'd0, 5, 1'b0, 7));
    for (int c = 1; c < 6; c++) put_b(c, 0, 1'b0);
    scan_b(1'b0, 2, 0, mk(1'b1, 2'd1, 5, 1'b0, 9));
    for (int k = 0; k < 5; k++) put_b(4 + k, k, 1'b1);
    scan_b(1'b1, 8, 4, mk(1'b1, 2'd2, 5, 1'b0, 11));

    check("s_queue_drained", s_q.size(), 0);
    check("b_queue_drained", b_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
